mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester (0) and a data requester (1). Simultaneous requests alternate
// between the two requesters. Each transaction ends with a one-cycle done
// pulse, or with a one-cycle err pulse when memory does not answer in time.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             owner_sel
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic            last_grant_r;  // 1: requester 1 was the last one served
  logic [CW-1:0]   cnt_inc_s;
  logic            grant0_s;
  logic            grant1_s;
  logic            unused_we0_s;

  // Requester 0 is a fetch port: its write enable is deliberately ignored.
  assign unused_we0_s = we0;

  // Arbitration decision and next wait count for the current cycle
  always_comb begin
    cnt_inc_s = cnt_r + CNT_ONE;
    grant0_s  = 1'b0;
    grant1_s  = 1'b0;
    if (req0 && (!req1 || last_grant_r)) begin
      grant0_s = 1'b1;
    end else if (req1) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Control FSM with registered memory-port, read-data and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      last_grant_r <= 1'b1;
      owner_sel    <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {WIDTH{1'b0}};
      mem_wdata    <= {WIDTH{1'b0}};
      rdata        <= {WIDTH{1'b0}};
      done0        <= 1'b0;
      done1        <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless set below.
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state_r)
        IDLE: begin
          // mem_ready is not looked at here: a stray ready in IDLE is ignored.
          if (grant0_s) begin
            state_r      <= BUSY0;
            mem_req      <= 1'b1;
            mem_addr     <= addr0;
            mem_wdata    <= wdata0;
            mem_we       <= 1'b0;
            owner_sel    <= 1'b1;
            last_grant_r <= 1'b0;
            cnt_r        <= CNT_ZERO;
          end else if (grant1_s) begin
            state_r      <= BUSY1;
            mem_req      <= 1'b1;
            mem_addr     <= addr1;
            mem_wdata    <= wdata1;
            mem_we       <= we1;
            owner_sel    <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= CNT_ZERO;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY0, BUSY1: begin
          // Requester inputs are not consulted: the latched request runs to
          // completion or timeout even if the requester drops or changes it.
          if (mem_ready) begin
            // Ready wins over timeout when both happen on the same cycle.
            state_r <= IDLE;
            mem_req <= 1'b0;
            done0   <= (state_r == BUSY0);
            done1   <= (state_r == BUSY1);
            if (!mem_we) begin
              rdata <= mem_rdata;
            end else begin
              rdata <= rdata;
            end
          end else if (cnt_inc_s == CNT_LIMIT) begin
            state_r <= IDLE;
            mem_req <= 1'b0;
            err0    <= (state_r == BUSY0);
            err1    <= (state_r == BUSY1);
            cnt_r   <= cnt_inc_s;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter. A transaction-level model
// decides each grant and the memory latency; expected outcomes are queued at
// grant time and a negedge monitor compares them against the DUT.
module tb_mem_port_arbiter;
  localparam int W = 32;
  localparam int T = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, we0, we1;
  logic [W-1:0] addr0, addr1, wdata0, wdata1;
  logic         done0, done1, err0, err1;
  logic [W-1:0] rdata;
  logic         mem_req, mem_we, mem_ready, owner_sel;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .owner_sel(owner_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           who;     // requester that won
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic         we;
    bit           is_err;
    logic [W-1:0] rd;      // data memory returns on completion
    int           g;       // grant edge
    int           fin;     // edge on which done/err is registered
  } txn_t;

  txn_t         sb_q[$];
  int           obs_ev[$];  // observed pulses: 0 done0, 1 done1, 2 err0, 3 err1
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           sb_on = 1'b0;
  bit           last_served = 1'b1;  // 1: requester 1 served last
  int           free_at = 0;
  int           ready_at = -1;
  int           busy_lo = -1;
  int           busy_hi = -1;
  int           force_lat = 0;
  bit           force_data_en = 1'b0;
  logic [W-1:0] force_data = '0;
  logic [W-1:0] ready_data = '0;
  logic [W-1:0] exp_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model, evaluated on the pins the DUT sampled this edge.
  task automatic model_edge();
    txn_t t;
    int   lat;
    if (cyc >= free_at && (req0 || req1)) begin
      t.who   = (req0 && (!req1 || last_served)) ? 0 : 1;
      t.addr  = (t.who == 1) ? addr1 : addr0;
      t.wdata = (t.who == 1) ? wdata1 : wdata0;
      t.we    = (t.who == 1) ? we1 : 1'b0;
      if (force_lat != 0) lat = force_lat;
      else if ($urandom_range(0, 3) == 0) lat = $urandom_range(T - 1, T + 2);
      else lat = $urandom_range(1, 4);
      t.g  = cyc;
      t.rd = force_data_en ? force_data : $urandom;
      if (lat <= T) begin
        t.is_err = 1'b0;
        t.fin    = cyc + lat;
        ready_at = cyc + lat;
      end else begin
        t.is_err = 1'b1;
        t.fin    = cyc + T;
        ready_at = -1;
      end
      ready_data  = t.rd;
      busy_lo     = cyc;
      busy_hi     = t.fin;
      free_at     = t.fin + 1;
      last_served = (t.who == 1);
      sb_q.push_back(t);
    end
  endtask

  // One clock: run the model on this edge, then drive inputs for the next.
  task automatic step(input logic r0, input logic r1, input logic [W-1:0] a0, input logic [W-1:0] a1,
                      input logic [W-1:0] d0, input logic [W-1:0] d1, input logic w0, input logic w1);
    int nxt;
    @(posedge clk);
    #1;
    model_edge();
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
    wdata0 = d0; wdata1 = d1; we0 = w0; we1 = w1;
    nxt = cyc + 1;
    if (nxt == ready_at) begin
      mem_ready = 1'b1;
      mem_rdata = ready_data;
    end else begin
      mem_ready = (nxt > busy_lo && nxt <= busy_hi) ? 1'b0 : 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: pops expectations when the DUT reports completion
  always @(negedge clk) begin : mon
    txn_t t;
    int   n;
    bit   busy;
    if (sb_on) begin
      n = int'(done0) + int'(done1) + int'(err0) + int'(err1);
      if (n != 0) begin
        chk_word("pulse_exclusive", n, 1);
        if (done0) obs_ev.push_back(0);
        else if (done1) obs_ev.push_back(1);
        else if (err0) obs_ev.push_back(2);
        else obs_ev.push_back(3);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got done=%b%b err=%b%b expected none (cycle %0d)",
                   done0, done1, err0, err1, cyc);
        end else begin
          t = sb_q.pop_front();
          chk_word("completion_cycle", cyc, t.fin);
          chk_bit("done0", done0, !t.is_err && t.who == 0);
          chk_bit("done1", done1, !t.is_err && t.who == 1);
          chk_bit("err0", err0, t.is_err && t.who == 0);
          chk_bit("err1", err1, t.is_err && t.who == 1);
          if (!t.is_err && !t.we) exp_rdata = t.rd;
        end
      end else if (sb_q.size() != 0 && sb_q[0].fin <= cyc) begin
        t = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: got none expected %s from requester %0d (cycle %0d)",
                 t.is_err ? "err" : "done", t.who, cyc);
      end
      chk_word("rdata", rdata, exp_rdata);
      busy = (sb_q.size() != 0) && (sb_q[0].g <= cyc);
      chk_bit("mem_req", mem_req, busy);
      if (busy) begin
        chk_word("mem_addr", mem_addr, sb_q[0].addr);
        chk_word("mem_wdata", mem_wdata, sb_q[0].wdata);
        chk_bit("mem_we", mem_we, sb_q[0].we);
        chk_bit("owner_sel", owner_sel, sb_q[0].who == 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_mem_req", mem_req, 1'b0);
    chk_bit("rst_mem_we", mem_we, 1'b0);
    chk_word("rst_mem_addr", mem_addr, '0);
    chk_word("rst_mem_wdata", mem_wdata, '0);
    chk_word("rst_rdata", rdata, '0);
    chk_bit("rst_done0", done0, 1'b0);
    chk_bit("rst_done1", done1, 1'b0);
    chk_bit("rst_err0", err0, 1'b0);
    chk_bit("rst_err1", err1, 1'b0);
    chk_bit("rst_owner_sel", owner_sel, 1'b1);
    rst = 1'b0;
    sb_on = 1'b1;

    // Single read from requester 0 (its write enable must be ignored).
    force_lat = 1; force_data_en = 1'b1; force_data = 32'hDEADBEEF;
    step(1'b1, 1'b0, 32'h00000040, '0, 32'h55555555, '0, 1'b1, 1'b0);
    idle(4);
    chk_word("read_rdata", rdata, 32'hDEADBEEF);
    chk_word("read_events", obs_ev.size(), 1);

    // Write from requester 1 leaves rdata alone.
    force_data = 32'hCAFEF00D;
    step(1'b0, 1'b1, '0, 32'h00000100, '0, 32'h12345678, 1'b0, 1'b1);
    idle(4);
    chk_word("write_keeps_rdata", rdata, 32'hDEADBEEF);
    force_data_en = 1'b0;

    // Contention: both held for four transactions -> 0,1,0,1.
    obs_ev.delete();
    repeat (7) step(1'b1, 1'b1, 32'h1000, 32'h2000, 32'h11, 32'h22, 1'b0, 1'b0);
    idle(3);
    chk_word("contention_count", obs_ev.size(), 4);
    if (obs_ev.size() == 4) begin
      chk_word("contention_0", obs_ev[0], 0);
      chk_word("contention_1", obs_ev[1], 1);
      chk_word("contention_2", obs_ev[2], 0);
      chk_word("contention_3", obs_ev[3], 1);
    end

    // Timeout: memory never answers.
    obs_ev.delete();
    force_lat = T + 1;
    step(1'b0, 1'b1, '0, 32'h200, '0, '0, 1'b0, 1'b0);
    idle(T + 3);
    chk_word("timeout_events", obs_ev.size(), 1);
    if (obs_ev.size() == 1) chk_word("timeout_err1", obs_ev[0], 3);

    // Boundary: ready on the last allowed BUSY cycle is a completion.
    obs_ev.delete();
    force_lat = T;
    step(1'b1, 1'b0, 32'h300, '0, '0, '0, 1'b0, 1'b0);
    idle(T + 3);
    chk_word("boundary_events", obs_ev.size(), 1);
    if (obs_ev.size() == 1) chk_word("boundary_done0", obs_ev[0], 0);

    // Random traffic with random latencies, stray ready in IDLE and
    // requester inputs changing while BUSY.
    force_lat = 0;
    repeat (3000) begin
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6), $urandom, $urandom,
           $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(T + 5);
    chk_word("random_drained", sb_q.size(), 0);

    // Reset two cycles into BUSY0, then re-arbitration from IDLE.
    force_lat = T + 1;
    step(1'b1, 1'b0, 32'h400, '0, '0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h500, 32'h600, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h500, 32'h600, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    sb_on = 1'b0;
    #1;
    chk_bit("midrst_mem_req", mem_req, 1'b0);
    chk_bit("midrst_owner_sel", owner_sel, 1'b1);
    chk_word("midrst_rdata", rdata, '0);
    @(negedge clk);
    chk_word("midrst_no_pulse", {28'd0, done0, done1, err0, err1}, '0);
    @(posedge clk);
    #1;
    chk_bit("midrst_mem_req_hold", mem_req, 1'b0);
    rst = 1'b0;
    sb_q.delete();
    last_served = 1'b1;
    free_at = 0; ready_at = -1; busy_lo = -1; busy_hi = -1;
    exp_rdata = '0;
    force_lat = 1;
    obs_ev.delete();
    sb_on = 1'b1;
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    idle(4);
    chk_word("postrst_events", obs_ev.size(), 1);
    if (obs_ev.size() == 1) chk_word("postrst_first_grant", obs_ev[0], 0);

    idle(T + 3);
    chk_word("final_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
